// File: rtl/fpu_issue_ctl.sv
// Issue/return sequencer between the IU FP opcode/operand bus and a multi-cycle FPU core.
// Collects operands in one or two beats, launches the core and returns results with hold, kill and watchdog.
module fpu_issue_ctl #(
    parameter int unsigned BUS_W   = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TCNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        fpop,
    input  logic              fpop_valid,
    input  logic [BUS_W-1:0]  fpain,
    input  logic [BUS_W-1:0]  fpbin,
    input  logic              fpkill,
    input  logic              fphold,
    output logic              fpbusyn,
    output logic [BUS_W-1:0]  fpout,
    output logic              fpout_valid,
    output logic              fperr,
    output logic              op_start,
    output logic [7:0]        op_code,
    output logic              op_dprec,
    output logic [63:0]       op_a,
    output logic [63:0]       op_b,
    output logic              op_kill,
    input  logic              core_done,
    input  logic [63:0]       core_res
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADB,
        S_EXEC,
        S_RES
    } state_t;

    state_t             state, state_d;
    logic [TCNT_W-1:0]  cnt, cnt_d;
    logic               is_cmp, is_cmp_d;
    logic               beat_idx, beat_idx_d;
    logic               done_pend, done_pend_d;
    logic [63:0]        res, res_d;

    logic               fpbusyn_d, fpout_valid_d, fperr_d, op_start_d, op_kill_d, op_dprec_d;
    logic [BUS_W-1:0]   fpout_d;
    logic [7:0]         op_code_d;
    logic [63:0]        op_a_d, op_b_d;

    logic               dec_ok_c, dec_dp_c, dec_cmp_c;
    logic               two_beat_c;
    logic               done_c;
    logic [63:0]        res_sel_c;
    logic [63:0]        nan_c;

    // Opcode decode: legal FP ops, precision and compare class
    always_comb begin
        dec_ok_c  = 1'b1;
        dec_dp_c  = 1'b0;
        dec_cmp_c = 1'b0;
        case (fpop)
            8'h62, 8'h66, 8'h6A, 8'h6E: ;
            8'h95, 8'h96:               dec_cmp_c = 1'b1;
            8'h63, 8'h67, 8'h6B, 8'h6F: dec_dp_c  = 1'b1;
            8'h97, 8'h98: begin
                dec_dp_c  = 1'b1;
                dec_cmp_c = 1'b1;
            end
            default:                    dec_ok_c  = 1'b0;
        endcase
    end

    assign two_beat_c = op_dprec && !is_cmp && (BUS_W == 32);
    assign done_c     = core_done || done_pend;
    assign res_sel_c  = done_pend ? res : core_res;
    assign nan_c      = is_cmp   ? 64'h0 :
                        op_dprec ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;

    function automatic logic [BUS_W-1:0] beat_of(input logic [63:0] r, input logic cmp,
                                                 input logic dp, input logic idx);
        if (cmp)
            return BUS_W'(signed'(r[31:0]));
        else if (dp && (BUS_W == 32) && !idx)
            return BUS_W'(r[63:32]);
        else if (dp)
            return r[BUS_W-1:0];
        else
            return BUS_W'(r[31:0]);
    endfunction

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        is_cmp_d      = is_cmp;
        beat_idx_d    = beat_idx;
        done_pend_d   = done_pend;
        res_d         = res;
        fpbusyn_d     = fpbusyn;
        fpout_d       = fpout;
        fpout_valid_d = fpout_valid;
        op_code_d     = op_code;
        op_dprec_d    = op_dprec;
        op_a_d        = op_a;
        op_b_d        = op_b;
        fperr_d       = 1'b0;
        op_start_d    = 1'b0;
        op_kill_d     = 1'b0;

        if (fpkill) begin
            state_d       = S_IDLE;
            cnt_d         = '0;
            done_pend_d   = 1'b0;
            beat_idx_d    = 1'b0;
            fpbusyn_d     = 1'b1;
            fpout_valid_d = 1'b0;
            op_kill_d     = (state == S_EXEC);
        end else if (fphold) begin
            // Frozen: pulses stretch, but a core result arriving now is remembered
            fperr_d    = fperr;
            op_start_d = op_start;
            op_kill_d  = op_kill;
            if (state == S_EXEC && core_done && !done_pend) begin
                done_pend_d = 1'b1;
                res_d       = core_res;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (fpop_valid && dec_ok_c) begin
                        op_code_d   = fpop;
                        op_dprec_d  = dec_dp_c;
                        is_cmp_d    = dec_cmp_c;
                        fpbusyn_d   = 1'b0;
                        cnt_d       = '0;
                        done_pend_d = 1'b0;
                        if (dec_dp_c && (BUS_W == 32)) begin
                            op_a_d  = {fpain[31:0], 32'h0};
                            op_b_d  = {fpbin[31:0], 32'h0};
                            state_d = S_LOADB;
                        end else begin
                            op_a_d     = dec_dp_c ? 64'(fpain) : 64'(fpain[31:0]);
                            op_b_d     = dec_dp_c ? 64'(fpbin) : 64'(fpbin[31:0]);
                            op_start_d = 1'b1;
                            state_d    = S_EXEC;
                        end
                    end
                end
                S_LOADB: begin
                    op_a_d     = {op_a[63:32], fpain[31:0]};
                    op_b_d     = {op_b[63:32], fpbin[31:0]};
                    op_start_d = 1'b1;
                    state_d    = S_EXEC;
                end
                S_EXEC: begin
                    // core_done is checked first so it wins over a coincident expiry
                    if (done_c || cnt == TCNT_W'(TIMEOUT - 1)) begin
                        res_d         = done_c ? res_sel_c : nan_c;
                        op_kill_d     = !done_c;
                        fperr_d       = !done_c;
                        state_d       = S_RES;
                        cnt_d         = '0;
                        done_pend_d   = 1'b0;
                        beat_idx_d    = 1'b0;
                        fpout_d       = beat_of(done_c ? res_sel_c : nan_c, is_cmp, op_dprec, 1'b0);
                        fpout_valid_d = 1'b1;
                        fpbusyn_d     = !two_beat_c;
                    end else begin
                        cnt_d = cnt + TCNT_W'(1);
                    end
                end
                S_RES: begin
                    if (two_beat_c && !beat_idx) begin
                        beat_idx_d = 1'b1;
                        fpout_d    = beat_of(res, is_cmp, op_dprec, 1'b1);
                        fpbusyn_d  = 1'b1;
                    end else begin
                        state_d       = S_IDLE;
                        beat_idx_d    = 1'b0;
                        fpout_valid_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_cmp      <= 1'b0;
            beat_idx    <= 1'b0;
            done_pend   <= 1'b0;
            res         <= '0;
            fpbusyn     <= 1'b1;
            fpout       <= '0;
            fpout_valid <= 1'b0;
            fperr       <= 1'b0;
            op_start    <= 1'b0;
            op_kill     <= 1'b0;
            op_code     <= '0;
            op_dprec    <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            is_cmp      <= is_cmp_d;
            beat_idx    <= beat_idx_d;
            done_pend   <= done_pend_d;
            res         <= res_d;
            fpbusyn     <= fpbusyn_d;
            fpout       <= fpout_d;
            fpout_valid <= fpout_valid_d;
            fperr       <= fperr_d;
            op_start    <= op_start_d;
            op_kill     <= op_kill_d;
            op_code     <= op_code_d;
            op_dprec    <= op_dprec_d;
            op_a        <= op_a_d;
            op_b        <= op_b_d;
        end
    end

endmodule

// File: doc/fpu_issue_ctl.md
Name: fpu_issue_ctl

Overview:
- Parametrised issue/return sequencer between the IU operand/opcode interface and a multi-cycle FPU datapath core.
- Latches Java FP opcodes and operands, and collects double-precision operands over one or two bus beats.
- Launches the core, then returns results in one or two beats, with hold, kill and a watchdog timeout.
- Successor to the fixed 32-bit FPU top interface: bus width is configurable, and kill, timeout and error reporting are explicit.

Parameters:
BUS_W, 32, operand/result bus width; legal values 32 or 64. At 64 a double moves in one beat.
TIMEOUT, 255, maximum EXEC cycles waiting for core_done before forced abort; must be >= 2.
TCNT_W, 8, width of the watchdog counter; must satisfy 2**TCNT_W > TIMEOUT.

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active high
fpop  in  8  Java FP opcode
fpop_valid  in  1  fpop valid
fpain  in  BUS_W  A operand beat
fpbin  in  BUS_W  B operand beat
fpkill  in  1  abort current operation
fphold  in  1  IU stall; freezes the block
fpbusyn  out  1  low while an operation is in progress
fpout  out  BUS_W  result beat
fpout_valid  out  1  fpout is valid this cycle
fperr  out  1  one-cycle pulse on watchdog abort
op_start  out  1  one-cycle launch pulse to the core
op_code  out  8  latched opcode
op_dprec  out  1  double-precision operation
op_a  out  64  A operand; single-precision value in [31:0]
op_b  out  64  B operand; single-precision value in [31:0]
op_kill  out  1  one-cycle abort pulse to the core
core_done  in  1  core result ready
core_res  in  64  core result; 32-bit results in [31:0]

Behaviour:
- Reset values: fpbusyn=1; fpout=0; fpout_valid=0; fperr=0; op_start=0; op_kill=0; op_code=0; op_dprec=0; op_a=0; op_b=0; state IDLE; watchdog counter 0.
- Decode, single precision: 0x62 fadd, 0x66 fsub, 0x6A fmul, 0x6E fdiv, 0x95 fcmpl, 0x96 fcmpg.
- Decode, double precision: 0x63 dadd, 0x67 dsub, 0x6B dmul, 0x6F ddiv, 0x97 dcmpl, 0x98 dcmpg.
- Any other opcode is ignored: the block stays in IDLE and fpbusyn stays 1.
- Compare ops always return a single 32-bit beat, in core_res[31:0], sign-extended to BUS_W.
- Result beats: double result = 2 beats when BUS_W=32 (high word then low word), 1 beat when BUS_W=64. All other results = 1 beat.
- IDLE: on fpop_valid with a decoded opcode, latch the opcode and operand beat.
  - Single op, or double op with BUS_W=64: go to EXEC and pulse op_start next cycle.
  - Double op with BUS_W=32: the accept beat carries the high words; go to LOADB.
  - fpbusyn goes 0 the cycle after accept.
- LOADB: the next non-held cycle carries the low words. Latch them, go to EXEC, pulse op_start.
- EXEC: the watchdog counter increments on each non-held cycle.
  - On core_done: capture core_res and go to RES.
  - If the counter reaches TIMEOUT without core_done: pulse op_kill and fperr.
  - After a timeout, return canonical NaN: single 0x7FC00000; double 0x7FF80000_00000000; compare ops 0x00000000.
- RES: drive one result beat per non-held cycle with fpout_valid=1.
  - fpbusyn returns to 1 in the same cycle as the last beat.
  - The state returns to IDLE the cycle after the last beat.
- A new fpop_valid is accepted only in IDLE; it is ignored in every other state.
- core_done outside EXEC is ignored.
- fphold=1 (and fpkill=0):
  - State, counter and all registered outputs hold.
  - Pulse outputs (op_start, op_kill, fperr) are extended: they are re-asserted until the first non-held cycle.
  - Inputs are not sampled while held; a core_done during hold is latched and acted on after hold drops.
- fpkill: priority over fphold and over everything except reset.
  - Next cycle: state IDLE, fpbusyn=1, fpout_valid=0, counter 0.
  - op_kill pulses only if the state was EXEC.
  - fpkill in IDLE has no effect. fpkill coincident with fpop_valid drops the new op.
- Reset mid-operation: returns immediately to reset values; no op_kill is issued.
- Simultaneous core_done and watchdog expiry in the same cycle: core_done wins; no error.

Test Plan:
- BUS_W=32, fadd (0x62), A=0x3F800000, B=0x40000000, core_done 3 cycles after op_start with res 0x40400000 -> op_start 1 cycle after accept; one beat fpout=0x40400000; fpbusyn high again on that beat.
- BUS_W=32, dmul (0x6B), beats {0x3FF00000,0x40000000} then {0,0} -> op_a=0x3FF00000_00000000, op_b=0x40000000_00000000; result 0x40000000_00000000 returned as beats 0x40000000 then 0x00000000.
- BUS_W=64, dcmpg (0x98) with core_res[31:0]=0xFFFFFFFF -> single beat fpout=0xFFFFFFFF_FFFFFFFF; op_start 1 cycle after accept.
- TIMEOUT=4, fdiv, core never answers -> after 4 EXEC cycles op_kill=1 and fperr=1 for one cycle; fpout=0x7FC00000 with fpout_valid=1.
- fphold high for 3 cycles during RES of a 2-beat double -> fpout/fpout_valid frozen; beat order preserved; fpkill asserted while fphold=1 -> IDLE next cycle with fpbusyn=1.
- fpop 0x60 (iadd) with fpop_valid=1 -> no launch; fpbusyn stays 1; op_start never pulses.
